regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we3/wa3/wd3) between two writeback sources: src0 (ALU) and src1 (load/memory).
- Each source gets a small queue with a valid/ready handshake.
- A round-robin arbiter drains the queues into registered write-port outputs.
- A pending-write mask lets the hazard logic stall reads of registers with queued writes.

Parameters:
DEPTH, 2, entries per source queue; power of 2, >= 2
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous clear of both queues and the output stage
src0_valid  in  1  ALU writeback request
src0_ready  out  1  src0 queue not full
src0_addr  in  AW  destination register
src0_data  in  DW  write data
src1_valid  in  1  load writeback request
src1_ready  out  1  src1 queue not full
src1_addr  in  AW  destination register
src1_data  in  DW  write data
we3  out  1  regfile write enable (registered)
wa3  out  AW  regfile write address (registered)
wd3  out  DW  regfile write data (registered)
pending  out  2**AW  bit r set while any queued or output-stage write targets r

Behaviour:
- Reset (reset=1 at an edge):
  - Queues emptied; we3=0, wa3=0, wd3=0.
  - last_grant=1, so src0 wins the first tie.
  - pending=0; src*_ready=1 from the following cycle.
- Handshake:
  - Transfer occurs when srcN_valid & srcN_ready at an edge.
  - srcN_ready = queue not full. It depends only on state, never on valid.
  - No pass-through when full: ready stays 0 even if a dequeue happens that cycle.
  - Enqueue and dequeue in the same cycle are legal when the queue is neither full nor empty, or when it is empty-then-enqueue only.
- x0: a transfer with addr==0 is accepted (handshake completes) but not enqueued. It never asserts we3 and never sets pending.
- Arbitration (combinational on queue heads):
  - Both heads valid: grant the source != last_grant.
  - One head valid: grant it.
  - Granting updates last_grant.
- Output stage:
  - At each edge, we3 <= (grant exists), and the granted head is popped.
  - wa3/wd3 load the granted head's addr/data.
  - When there is no grant, wa3/wd3 hold their value and we3=0.
- Latency:
  - An entry accepted at edge k into an empty, uncontested queue appears on we3/wa3/wd3 after edge k+1.
  - The regfile commits it at edge k+2.
  - Sustained throughput is one write per cycle total.
- Fairness: with both sources continuously non-empty, grants strictly alternate.
- pending: OR of decoded addresses of all valid entries in both queues plus (we3 ? wa3 : none). Combinational, bit 0 always 0.
- Ordering:
  - FIFO order within a source.
  - No ordering across sources. Upstream must not issue same-address writes from both sources concurrently; the pending mask is provided for this.
- flush:
  - Empties both queues and forces we3=0 at the next edge; pending=0 after that edge.
  - Transfers presented in the flush cycle are discarded.
  - reset has priority over flush; flush does not reset last_grant.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined adds these ports:
  - ra1, ra2 (in, AW);
  - rf_rd1, rf_rd2 (in, DW, raw regfile read data);
  - rd1, rd2 (out, DW).
- Defined behaviour:
  - rdN = wd3 when we3 & (wa3==raN) & (raN!=0); otherwise rf_rdN.
  - This covers the write in flight this cycle, which the regfile has not yet committed.
- Undefined: these ports are absent and the read path connects directly to the regfile.

Decomposition:
- Package regfile_pkg:
  - constants AW=5, DW=32, NSRC=2, SRC_ALU=0, SRC_MEM=1;
  - typedef wb_req_t {addr, data}.
- Sub-module regfile_wb_fifo: a synchronous FIFO with DEPTH entries.
  - Ports: push, pop, full, empty, head.
  - Also exports a per-entry valid/addr vector for pending generation.
  - Instantiated once per source.

Test Plan:
- Reset: assert reset for 2 cycles with src0_valid=1, addr=3 -> we3=0 and pending=0 throughout; src0_ready=1 after release.
- Single write: src0 addr=5, data=0xDEADBEEF, accepted at edge k -> after edge k+1: we3=1, wa3=5, wd3=DEADBEEF; pending[5]=1 from k until after edge k+2.
- Contention: both sources valid every cycle, src0 addrs 1,2,3 and src1 addrs 9,10,11 -> wa3 sequence 1,9,2,10,3,11; no lost or duplicated writes.
- Backpressure:
  - Hold src1 valid for 4 cycles with src0 also saturating; DEPTH=2.
  - Expect src1_ready=0 when full, and exactly 4 src1 writes emerge in order.
- x0 and flush:
  - src0 addr=0 data=0x1234 -> handshake completes, we3 never 1, pending=0.
  - Then fill both queues and pulse flush -> we3=0 next cycle, pending=0, no queued data ever written.
- Bypass (with REGFILE_WB_BYPASS_EN):
  - we3=1, wa3=7, wd3=0xCAFEF00D, ra1=7, rf_rd1=0 -> rd1=0xCAFEF00D.
  - ra2=0 -> rd2=rf_rd2.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NSRC = 2;

  // Source identifiers, also used as the encoding of the last-grant register.
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO holding pending writebacks for one source.
// Also exposes every slot's valid bit and address so the parent can
// build the pending-write mask without waiting for entries to reach the head.
module regfile_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic          do_push, do_pop;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; clear drops all entries at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Entry storage; contents are qualified by the occupancy, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      addr_q[wr_ptr_q] <= push_addr;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
      ent_addr[i]  = addr_q[i];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the
// ALU (src0) and load (src1) writeback queues, with a pending-write mask.
// Optional read bypass of the in-flight write: define REGFILE_WB_BYPASS_EN.
module regfile_wb_arbiter
  import regfile_pkg::SRC_ALU, regfile_pkg::SRC_MEM;
#(
  parameter int DEPTH = 2,
  parameter int AW    = regfile_pkg::AW,
  parameter int DW    = regfile_pkg::DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              src0_valid,
  output logic              src0_ready,
  input  logic [AW-1:0]     src0_addr,
  input  logic [DW-1:0]     src0_data,
  input  logic              src1_valid,
  output logic              src1_ready,
  input  logic [AW-1:0]     src1_addr,
  input  logic [DW-1:0]     src1_data,
  output logic              we3,
  output logic [AW-1:0]     wa3,
  output logic [DW-1:0]     wd3,
  output logic [2**AW-1:0]  pending
`ifdef REGFILE_WB_BYPASS_EN
  ,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  input  logic [DW-1:0]     rf_rd1,
  input  logic [DW-1:0]     rf_rd2,
  output logic [DW-1:0]     rd1,
  output logic [DW-1:0]     rd2
`endif
);

  logic                     full0, empty0, full1, empty1;
  logic                     push0, push1, pop0, pop1;
  logic [AW-1:0]            head_addr0, head_addr1;
  logic [DW-1:0]            head_data0, head_data1;
  logic [DEPTH-1:0]         ent_vld0, ent_vld1;
  logic [DEPTH-1:0][AW-1:0] ent_addr0, ent_addr1;

  logic                     grant_vld, grant_src;
  logic                     we3_q, we3_d;
  logic [AW-1:0]            wa3_q, wa3_d;
  logic [DW-1:0]            wd3_q, wd3_d;
  logic                     last_grant_q, last_grant_d;
  logic [2**AW-1:0]         pending_mask;

  // Ready reflects queue state only. Writes to x0 complete the handshake
  // but are dropped here, so they never reach the write port or the mask.
  assign src0_ready = ~full0;
  assign src1_ready = ~full1;
  assign push0 = src0_valid & ~full0 & ~flush & (src0_addr != '0);
  assign push1 = src1_valid & ~full1 & ~flush & (src1_addr != '0);

  regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_alu (
    .clk(clk), .reset(reset), .clear(flush),
    .push(push0), .push_addr(src0_addr), .push_data(src0_data),
    .pop(pop0), .full(full0), .empty(empty0),
    .head_addr(head_addr0), .head_data(head_data0),
    .ent_valid(ent_vld0), .ent_addr(ent_addr0)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo_mem (
    .clk(clk), .reset(reset), .clear(flush),
    .push(push1), .push_addr(src1_addr), .push_data(src1_data),
    .pop(pop1), .full(full1), .empty(empty1),
    .head_addr(head_addr1), .head_data(head_data1),
    .ent_valid(ent_vld1), .ent_addr(ent_addr1)
  );

  // Round-robin choice between the two queue heads.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = SRC_ALU;
    if (!empty0 && !empty1) begin
      grant_vld = 1'b1;
      grant_src = (last_grant_q == SRC_ALU) ? SRC_MEM : SRC_ALU;
    end else if (!empty0) begin
      grant_vld = 1'b1;
      grant_src = SRC_ALU;
    end else if (!empty1) begin
      grant_vld = 1'b1;
      grant_src = SRC_MEM;
    end
  end

  // Output-stage next state: load the winner and pop it; flush suppresses both.
  always_comb begin
    we3_d        = 1'b0;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    pop0         = 1'b0;
    pop1         = 1'b0;
    if (!flush && grant_vld) begin
      we3_d        = 1'b1;
      last_grant_d = grant_src;
      if (grant_src == SRC_MEM) begin
        wa3_d = head_addr1;
        wd3_d = head_data1;
        pop1  = 1'b1;
      end else begin
        wa3_d = head_addr0;
        wd3_d = head_data0;
        pop0  = 1'b1;
      end
    end
  end

  // Output-stage registers; last grant starts on the load source so the ALU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      last_grant_q <= SRC_MEM;
    end else begin
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Pending mask: every live queue slot plus the write currently on the port.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld0[i]) pending_mask[ent_addr0[i]] = 1'b1;
      if (ent_vld1[i]) pending_mask[ent_addr1[i]] = 1'b1;
    end
    if (we3_q) pending_mask[wa3_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign pending = pending_mask;

`ifdef REGFILE_WB_BYPASS_EN
  // Forward the write the regfile has not committed yet; x0 always reads raw.
  assign rd1 = (we3_q && (wa3_q == ra1) && (ra1 != '0)) ? wd3_q : rf_rd1;
  assign rd2 = (we3_q && (wa3_q == ra2) && (ra2 != '0)) ? wd3_q : rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic          src0_valid, src0_ready, src1_valid, src1_ready;
  logic [AW-1:0] src0_addr, src1_addr, wa3;
  logic [DW-1:0] src0_data, src1_data, wd3;
  logic          we3;
  logic [31:0]   pending;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rf_rd1, rf_rd2, rd1, rd2;
`endif

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] s0_q[$], s1_q[$], log_a[$];
  logic [DW-1:0] log_d[$];
  bit            saw_nr1;
  int            acc_cnt0, acc_cnt1;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready),
    .src1_addr(src1_addr), .src1_data(src1_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending)
`ifdef REGFILE_WB_BYPASS_EN
    , .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1(rd1), .rd2(rd2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] dat(input logic src, input logic [AW-1:0] a);
    return {(src ? 8'hB0 : 8'hA0), 19'h0, a};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Drive both source streams with handshakes for a fixed number of cycles,
  // logging every write that appears on the port.
  task automatic stream(input int cycles);
    int  i0 = 0, i1 = 0;
    bit  a0, a1;
    log_a.delete();
    log_d.delete();
    saw_nr1 = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      src0_valid = (i0 < s0_q.size());
      src0_addr  = src0_valid ? s0_q[i0] : '0;
      src0_data  = dat(1'b0, src0_addr);
      src1_valid = (i1 < s1_q.size());
      src1_addr  = src1_valid ? s1_q[i1] : '0;
      src1_data  = dat(1'b1, src1_addr);
      if (src1_valid && !src1_ready) saw_nr1 = 1'b1;
      a0 = src0_valid && src0_ready;
      a1 = src1_valid && src1_ready;
      tick();
      if (a0) i0++;
      if (a1) i1++;
      if (we3) begin
        log_a.push_back(wa3);
        log_d.push_back(wd3);
      end
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    acc_cnt0 = i0;
    acc_cnt1 = i1;
  endtask

  initial begin
    logic [AW-1:0] exp_a[6];
    logic          exp_s[6];
    int            n0, n1, wcount;

    reset = 1'b1; flush = 1'b0;
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'h33;
    src1_valid = 1'b0; src1_addr = '0;   src1_data = '0;
`ifdef REGFILE_WB_BYPASS_EN
    ra1 = '0; ra2 = '0; rf_rd1 = '0; rf_rd2 = '0;
`endif

    // Reset held two cycles with a request present
    tick();
    chk("rst1_we3", we3, 0);
    chk("rst1_pending", pending, 0);
    tick();
    chk("rst2_we3", we3, 0);
    chk("rst2_pending", pending, 0);
    reset = 1'b0;
    src0_valid = 1'b0;
    chk("rst_src0_ready", src0_ready, 1);
    chk("rst_src1_ready", src1_ready, 1);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);

    // Single write and its latency / pending window
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'hDEADBEEF;
    chk("single_pend_before", pending, 0);
    chk("single_ready", src0_ready, 1);
    tick();
    src0_valid = 1'b0;
    chk("single_k_we3", we3, 0);
    chk("single_k_pend", pending, 32'h20);
    tick();
    chk("single_k1_we3", we3, 1);
    chk("single_k1_wa3", wa3, 5);
    chk("single_k1_wd3", wd3, 32'hDEADBEEF);
    chk("single_k1_pend", pending, 32'h20);
    tick();
    chk("single_k2_we3", we3, 0);
    chk("single_k2_pend", pending, 0);
    chk("single_k2_wa3_hold", wa3, 5);

    // Contention from reset: ALU wins first tie, then strict alternation
    do_reset();
    s0_q = '{5'd1, 5'd2, 5'd3};
    s1_q = '{5'd9, 5'd10, 5'd11};
    stream(12);
    exp_a = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    exp_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    chk("cont_acc0", acc_cnt0, 3);
    chk("cont_acc1", acc_cnt1, 3);
    chk("cont_count", log_a.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("cont_wa3_%0d", i), (i < log_a.size()) ? log_a[i] : 5'h1F, exp_a[i]);
      chk($sformatf("cont_wd3_%0d", i), (i < log_d.size()) ? log_d[i] : 32'h0, dat(exp_s[i], exp_a[i]));
    end

    // Backpressure: four src1 writes against a saturating src0, queue depth 2
    s0_q = '{5'd12, 5'd13, 5'd14, 5'd15};
    s1_q = '{5'd20, 5'd21, 5'd22, 5'd23};
    stream(20);
    chk("bp_src1_not_ready_seen", saw_nr1, 1);
    chk("bp_acc1", acc_cnt1, 4);
    chk("bp_count", log_a.size(), 8);
    n0 = 0; n1 = 0;
    for (int i = 0; i < log_a.size(); i++) begin
      if (log_a[i] >= 5'd20) begin
        chk($sformatf("bp_src1_order_%0d", n1), log_a[i], 5'd20 + 5'(n1));
        chk($sformatf("bp_src1_data_%0d", n1), log_d[i], dat(1'b1, 5'd20 + 5'(n1)));
        n1++;
      end else begin
        chk($sformatf("bp_src0_order_%0d", n0), log_a[i], 5'd12 + 5'(n0));
        n0++;
      end
    end
    chk("bp_src1_writes", n1, 4);
    chk("bp_src0_writes", n0, 4);

    // x0: handshake completes, nothing written, nothing pending
    src0_valid = 1'b1; src0_addr = 5'd0; src0_data = 32'h1234;
    chk("x0_ready", src0_ready, 1);
    tick();
    src0_valid = 1'b0;
    chk("x0_pend", pending, 0);
    wcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (we3) wcount++;
      tick();
    end
    chk("x0_no_write", wcount, 0);
    chk("x0_pend_after", pending, 0);

    // Flush with both queues loaded and new transfers presented in the flush cycle
    src0_valid = 1'b1; src0_addr = 5'd16; src0_data = 32'h16;
    src1_valid = 1'b1; src1_addr = 5'd17; src1_data = 32'h17;
    tick();
    src0_addr = 5'd18; src1_addr = 5'd19;
    tick();
    chk("fl_pend_before", pending, 32'h000F_0000);
    src0_addr = 5'd26; src1_addr = 5'd27;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0;
    chk("fl_we3", we3, 0);
    chk("fl_pend", pending, 0);
    chk("fl_ready0", src0_ready, 1);
    chk("fl_ready1", src1_ready, 1);
    wcount = 0;
    for (int c = 0; c < 5; c++) begin
      if (we3) wcount++;
      tick();
    end
    chk("fl_no_write", wcount, 0);

    // Port still works after a flush
    src1_valid = 1'b1; src1_addr = 5'd6; src1_data = 32'h600D;
    tick();
    src1_valid = 1'b0;
    tick();
    chk("post_fl_we3", we3, 1);
    chk("post_fl_wa3", wa3, 6);
    chk("post_fl_wd3", wd3, 32'h600D);

`ifdef REGFILE_WB_BYPASS_EN
    // Bypass of the in-flight write
    tick();
    src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'hCAFEF00D;
    ra1 = 5'd7; rf_rd1 = 32'h0; ra2 = 5'd0; rf_rd2 = 32'h1111_2222;
    tick();
    src0_valid = 1'b0;
    chk("byp_idle_rd1", rd1, 32'h0);
    tick();
    chk("byp_we3", we3, 1);
    chk("byp_rd1", rd1, 32'hCAFEF00D);
    chk("byp_rd2_x0", rd2, 32'h1111_2222);
    ra2 = 5'd7;
    #1;
    chk("byp_rd2_hit", rd2, 32'hCAFEF00D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
